// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write engine.
// One frame: START, 3 bytes each followed by an ACK slot, STOP.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START0,
    S_START1,
    S_BIT,
    S_STOP0,
    S_STOP1,
    S_STOP2,
    S_DONE
  } state_t;

  localparam int QUARTERS_PER_BIT = 4;
  localparam int SLOTS = 27;
  localparam int FRAME_BITS = 24;

  localparam logic [2:0][4:0] ACK_SLOTS =
    {5'd26, 5'd17, 5'd8};

  function automatic logic is_ack_slot(
    input logic [4:0] s
  );
    return (s == ACK_SLOTS[0]) ||
           (s == ACK_SLOTS[1]) ||
           (s == ACK_SLOTS[2]);
  endfunction

  function automatic logic [1:0] byte_index(
    input logic [4:0] s
  );
    if (s >= 5'd18) return 2'd2;
    if (s >= 5'd9)  return 2'd1;
    return 2'd0;
  endfunction

  // Frame bit carried by a data slot (ACK slots are skipped).
  function automatic logic [4:0] data_index(
    input logic [4:0] s
  );
    return 5'd23 - (s - {3'b000, byte_index(s)});
  endfunction

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter/slot counter for the bit phase of a frame.
// Exposes current and next values so outputs can be registered.
module i2c_bit_timer
  import i2c_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  output logic [1:0] o_q,
  output logic [4:0] o_slot,
  output logic [1:0] o_q_nxt,
  output logic [4:0] o_slot_nxt,
  output logic       o_last
);

  localparam logic [1:0] LAST_Q =
    2'(QUARTERS_PER_BIT - 1);
  localparam logic [4:0] LAST_SLOT =
    5'(SLOTS - 1);

  logic [1:0] r_q;
  logic [4:0] r_slot;

  assign o_q    = r_q;
  assign o_slot = r_slot;
  assign o_last = (r_q == LAST_Q) &&
                  (r_slot == LAST_SLOT);

  // Advance one quarter per cycle while running, else park at 0.
  always_comb begin
    o_q_nxt    = 2'd0;
    o_slot_nxt = 5'd0;
    if (i_run) begin
      if (r_q == LAST_Q) begin
        o_q_nxt    = 2'd0;
        o_slot_nxt = o_last ? 5'd0 : r_slot + 5'd1;
      end else begin
        o_q_nxt    = r_q + 2'd1;
        o_slot_nxt = r_slot;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= 2'd0;
      r_slot <= 5'd0;
    end else begin
      r_q    <= o_q_nxt;
      r_slot <= o_slot_nxt;
    end
  end

endmodule

// File: rtl/i2c_write_controller.sv
// Single-master I2C write engine: one 24-bit frame per GO.
// SCLK and SDA enable are registered from next-state decode.
module i2c_write_controller
  import i2c_pkg::*;
(
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [FRAME_BITS-1:0] I2C_DATA,
  input  logic                  GO,
  output logic                  END,
  output logic [2:0]            ACK,
  output logic                  I2C_SCLK,
  inout  wire                   I2C_SDAT
);

  state_t r_state;
  state_t w_next;

  logic [FRAME_BITS-1:0] r_frame;
  logic [2:0] r_ack;
  logic       r_sclk;
  logic       r_sda_oe;
  logic       r_end;

  logic [1:0] w_q;
  logic [1:0] w_q_nxt;
  logic [4:0] w_slot;
  logic [4:0] w_slot_nxt;
  logic       w_last;
  logic       w_sclk;
  logic       w_sda_oe;
  logic       w_run;

  assign w_run    = (r_state == S_BIT);
  assign END      = r_end;
  assign ACK      = r_ack;
  assign I2C_SCLK = r_sclk;
  assign I2C_SDAT = r_sda_oe ? 1'b0 : 1'bz;

  i2c_bit_timer u_timer (
    .i_clk      (CLOCK),
    .i_rst      (RESET),
    .i_run      (w_run),
    .o_q        (w_q),
    .o_slot     (w_slot),
    .o_q_nxt    (w_q_nxt),
    .o_slot_nxt (w_slot_nxt),
    .o_last     (w_last)
  );

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (GO && !r_end) w_next = S_START0;
      S_START0: w_next = S_START1;
      S_START1: w_next = S_BIT;
      S_BIT:    if (w_last) w_next = S_STOP0;
      S_STOP0:  w_next = S_STOP1;
      S_STOP1:  w_next = S_STOP2;
      S_STOP2:  w_next = S_DONE;
      S_DONE:   if (!GO) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus levels for the cycle the next state occupies.
  always_comb begin
    w_sclk   = 1'b1;
    w_sda_oe = 1'b0;
    unique case (w_next)
      S_START0: w_sda_oe = 1'b1;
      S_START1: begin
        w_sclk   = 1'b0;
        w_sda_oe = 1'b1;
      end
      S_BIT: begin
        w_sclk   = (w_q_nxt == 2'd1) ||
                   (w_q_nxt == 2'd2);
        w_sda_oe = !is_ack_slot(w_slot_nxt) &&
                   !r_frame[data_index(w_slot_nxt)];
      end
      S_STOP0: begin
        w_sclk   = 1'b0;
        w_sda_oe = 1'b1;
      end
      S_STOP1:  w_sda_oe = 1'b1;
      default:  ;
    endcase
  end

  // State, output registers, frame latch and ACK capture.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_frame  <= '0;
      r_ack    <= 3'b000;
      r_sclk   <= 1'b1;
      r_sda_oe <= 1'b0;
      r_end    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sclk   <= w_sclk;
      r_sda_oe <= w_sda_oe;
      r_end    <= (w_next == S_DONE);
      if (r_state == S_IDLE && w_next == S_START0) begin
        r_frame <= I2C_DATA;
        r_ack   <= 3'b000;
      end
      if (w_run && w_q == 2'd2 && is_ack_slot(w_slot))
        r_ack[byte_index(w_slot)] <= I2C_SDAT;
    end
  end

endmodule

// File: tb/tb_i2c_write_controller.sv
// Bench for i2c_write_controller: bus decoder, ACKing slave,
// frame scoreboard, handshake, hold, abort and reset sequences.
module tb_i2c_write_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [23:0] data;
  logic        w_end;
  logic [2:0]  w_ack;
  logic        w_sclk;
  wire         w_sda;
  logic        slave_drv = 1'b0;
  logic [2:0]  mask = 3'b000;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_stop   = 0;

  logic [23:0] sb[$];

  typedef struct {
    logic [23:0] data;
    logic [2:0]  mask;
    logic [2:0]  ack;
  } vec_t;

  vec_t vec[11];

  pullup (w_sda);
  assign w_sda = slave_drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_write_controller dut (
    .CLOCK    (clk),
    .RESET    (rst),
    .I2C_DATA (data),
    .GO       (go),
    .END      (w_end),
    .ACK      (w_ack),
    .I2C_SCLK (w_sclk),
    .I2C_SDAT (w_sda)
  );

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  // Bus decoder and slave ACK model, sampled mid-cycle.
  initial begin : monitor
    logic p_scl, p_sda, scl, sda, in_frame;
    logic [23:0] got;
    int bitcnt, nbytes;
    logic [23:0] e;
    p_scl = 1'b1; p_sda = 1'b1; in_frame = 1'b0;
    got = '0; bitcnt = 0; nbytes = 0;
    forever begin
      @(negedge clk);
      scl = w_sclk;
      sda = w_sda;
      if (p_scl && scl && p_sda && !sda) begin
        n_start++;
        in_frame = 1'b1;
        bitcnt = 0; nbytes = 0; got = '0;
        slave_drv = 1'b0;
      end else if (p_scl && scl && !p_sda && sda) begin
        n_stop++;
        slave_drv = 1'b0;
        if (in_frame) begin
          if (sb.size() == 0) begin
            check("unexpected_frame", {8'(nbytes), got}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("frame", {8'(nbytes), got}, {8'd3, e});
          end
        end
        in_frame = 1'b0;
      end else if (!p_scl && scl && in_frame) begin
        bitcnt++;
        if (bitcnt <= 8 && nbytes < 3)
          got = {got[22:0], sda};
        if (bitcnt == 9) nbytes++;
      end else if (p_scl && !scl && in_frame) begin
        if (bitcnt == 8 && nbytes < 3) begin
          slave_drv = !mask[nbytes];
        end else if (bitcnt == 9) begin
          slave_drv = 1'b0;
          bitcnt = 0;
        end
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_frame(input logic [23:0] d,
                           input logic [2:0] m,
                           input logic [2:0] a,
                           input bit drop);
    int n;
    mask = m;
    sb.push_back(d);
    data = d;
    go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data = ~d;
    n = 0;
    while (!w_end && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, 113);
    check("ack", {29'd0, w_ack}, {29'd0, a});
    if (drop) begin
      go = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("end_clear", {31'd0, w_end}, 0);
    end
  endtask

  initial begin : stim
    int s, bad, n;
    vec[0]  = '{24'h341E00, 3'b000, 3'b000};
    vec[1]  = '{24'h340416, 3'b100, 3'b100};
    vec[2]  = '{24'h34001A, 3'b000, 3'b000};
    vec[3]  = '{24'h34021A, 3'b000, 3'b000};
    vec[4]  = '{24'h34047B, 3'b000, 3'b000};
    vec[5]  = '{24'h34067B, 3'b000, 3'b000};
    vec[6]  = '{24'h3408F8, 3'b010, 3'b010};
    vec[7]  = '{24'h340A06, 3'b000, 3'b000};
    vec[8]  = '{24'h340C00, 3'b000, 3'b000};
    vec[9]  = '{24'h340E01, 3'b111, 3'b111};
    vec[10] = '{24'h341002, 3'b000, 3'b000};

    rst = 1'b1; go = 1'b0; data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", {31'd0, w_sclk}, 1);
    check("rst_sda", {31'd0, w_sda}, 1);
    check("rst_end", {31'd0, w_end}, 0);
    check("rst_ack", {29'd0, w_ack}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_bus", {w_sclk, w_sda, 30'(n_start)},
          {2'b11, 30'd0});

    for (int i = 0; i < 11; i++)
      run_frame(vec[i].data, vec[i].mask, vec[i].ack, 1'b1);

    run_frame(24'h3412AA, 3'b000, 3'b000, 1'b0);
    s = n_start;
    bad = 0;
    repeat (300) begin
      @(posedge clk);
      @(negedge clk);
      if (!w_end) bad++;
    end
    check("hold_no_restart", 32'(n_start - s), 0);
    check("hold_end_high", bad, 0);
    go = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("hold_end_clear", {31'd0, w_end}, 0);

    mask = 3'b001;
    sb.push_back(24'h34A55A);
    data = 24'h34A55A;
    go = 1'b1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!w_end && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("drop_end_seen", {31'd0, w_end}, 1);
    check("drop_ack", {29'd0, w_ack}, 3'b001);
    @(posedge clk);
    @(negedge clk);
    check("drop_end_pulse", {31'd0, w_end}, 0);

    mask = 3'b001;
    data = 24'h341E00;
    go = 1'b1;
    @(posedge clk);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("pre_rst_ack", {29'd0, w_ack}, 3'b001);
    rst = 1'b1;
    go = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_bus", {30'd0, w_sclk, w_sda}, 2'b11);
    check("mid_rst_end", {31'd0, w_end}, 0);
    check("mid_rst_ack", {29'd0, w_ack}, 0);
    rst = 1'b0;
    s = n_stop;
    run_frame(24'h341E00, 3'b000, 3'b000, 1'b1);
    check("post_rst_stop", 32'(n_stop - s), 1);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_write_controller.md
Name: i2c_write_controller

Overview:
- Single-master I2C write engine. Sends one 24-bit frame per GO request: START, slave-address byte, sub-address byte, data byte, STOP.
- Samples the slave ACK after each byte.
- Sits under the codec configuration sequencer, which steps through a register table one frame at a time using the GO/END handshake.
- CLOCK is the slow bit-rate clock (about 10 kHz); one bit takes 4 CLOCK cycles.

Parameters:
- None. Frame width is fixed at 24 bits: 3 bytes, MSB first.

Ports:
- CLOCK  input  1  controller clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- I2C_DATA  input  24  {slave_addr[23:16], sub_addr[15:8], data[7:0]}; latched when GO is accepted.
- GO  input  1  level request; a rising request starts one frame.
- END  output  1  frame complete; held high while GO stays high.
- ACK  output  3  sampled ACK bits, 1 = NACK. ACK[0] is the address byte, ACK[1] the sub-address byte, ACK[2] the data byte.
- I2C_SCLK  output  1  I2C clock, registered, push-pull.
- I2C_SDAT  inout  1  I2C data, open-drain: drives 0 or Z, never drives 1.

Behaviour:
- Reset (sync, RESET=1 at an edge) goes to IDLE:
  - I2C_SCLK=1, SDAT released, END=0, ACK=3'b000.
  - Shift register and counters cleared.
  - Applies mid-frame: the frame is abandoned with no STOP generated.
- States: IDLE, START0, START1, BIT (27 slots x 4 quarters), STOP0, STOP1, STOP2, DONE.
- IDLE:
  - SCLK=1, SDA released.
  - If GO=1 and END=0 at an edge: latch I2C_DATA, clear ACK, go to START0.
- START0: SCLK=1, SDA=0 (start condition).
- START1: SCLK=0, SDA=0.
- BIT slot k (k = 0..26). Slots 8, 17 and 26 are ACK slots; the others carry data bits MSB first.
  - q0: SCLK=0; SDA set to the bit (0 drives low, 1 releases), or released in an ACK slot.
  - q1: SCLK=1.
  - q2: SCLK=1; in an ACK slot, SDAT is sampled on the q2 closing edge into the matching ACK bit.
  - q3: SCLK=0.
- STOP0: SCLK=0, SDA=0. STOP1: SCLK=1, SDA=0. STOP2: SCLK=1, SDA released (stop condition).
- DONE:
  - END=1, bus idle.
  - Stays in DONE while GO=1.
  - The first edge with GO=0 clears END and returns to IDLE (END low one cycle after GO falls).
- Latency: counting the edge that accepts GO as edge 0, END rises at edge 113 (2 + 108 + 3 bus cycles).
- NACK does not abort: the frame always completes, and ACK reports the sampled values. ACK holds until the next accepted GO or reset.
- GO dropping mid-frame is ignored: the frame completes, END pulses for one cycle, then the block returns to IDLE.
- GO held high after DONE does not restart. A new frame needs GO low for at least one edge, then GO high again.
- I2C_DATA changes after acceptance are ignored.
- SDAT read treats Z/pull-up as 1.
- SCLK and the SDA drive enable come straight from registers (no combinational gating of CLOCK).

Decomposition:
- Shared package i2c_pkg:
  - state enum;
  - constants QUARTERS_PER_BIT=4, SLOTS=27, ACK_SLOTS={8,17,26};
  - FRAME_BITS=24.
- One natural sub-module: i2c_bit_timer, a quarter/slot counter producing q-phase and slot index. Everything else stays inline.

Test Plan:
- Reset: hold RESET 3 cycles -> SCLK=1, SDAT=Z, END=0, ACK=000; release with GO=0 -> bus stays idle.
- Frame 0x34_1E_00, slave model ACKs every byte:
  - monitor decodes START, bytes 0x34, 0x1E, 0x00, STOP;
  - ACK=000;
  - END rises at edge 113 after GO is accepted;
  - SDAT never driven to 1.
- Slave NACKs the data byte only (frame 0x34_04_16) -> frame still completes with STOP; ACK=100.
- Handshake as in the sequencer:
  - GO=1, wait END, GO=0 one cycle, GO=1 with new data -> END low within 1 cycle of GO falling, second frame starts;
  - nine back-to-back frames all decoded correctly.
- GO held high after END -> no second START appears for 300 cycles; END stays 1.
- RESET asserted during slot 12 -> next edge SCLK=1, SDAT=Z, END=0; a following GO runs a clean full frame.
